qam64_frame_sequencer: RTL and testbench

Sequences the 64-QAM symbol store. It hunts the two-word frame header in the incoming 6-bit baseband symbol stream and maps the 512 payload symbols to I/Q nibbles. It writes those nibbles into the external 512×8 symbol memory and arbitrates that memory's single port against register accesses from the SPI slave. It sits between the baseband deserializer, the SPI slave and the symbol memory, and owns the mapping-control register (address 512) and the scratch register (address 513).

---
 rtl/qam64_pkg.sv | 25 ++
 rtl/qam64_symbol_mapper.sv | 11 +
 rtl/qam64_frame_sequencer.sv | 174 +++++++++++++++++
 tb/tb_qam64_frame_sequencer.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qam64_pkg.sv
// rtl/qam64_pkg.sv - shared types, register map and symbol mapping for the 64-QAM frame sequencer
package qam64_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        FILL
    } state_t;

    localparam logic [9:0] ADDR_CTRL    = 10'd512;
    localparam logic [9:0] ADDR_SCRATCH = 10'd513;
    localparam logic [9:0] ADDR_FCNT    = 10'd514;

    localparam int CTRL_MAP_EN_BIT = 0;
    localparam int CTRL_BUSY_BIT   = 1;

    localparam logic [5:0] HDR0_DEFAULT = 6'b101100;
    localparam logic [5:0] HDR1_DEFAULT = 6'b111000;

    // Code k sits at amplitude 7-2k; the 4-bit wrap yields the two's complement directly.
    function automatic logic [3:0] map_code(input logic [2:0] k);
        return 4'd7 - {k, 1'b0};
    endfunction

endpackage

// File: rtl/qam64_symbol_mapper.sv
// rtl/qam64_symbol_mapper.sv - combinational 6-bit symbol code to {I[3:0], Q[3:0]} mapper
module qam64_symbol_mapper
    import qam64_pkg::*;
(
    input  logic [5:0] code,
    output logic [7:0] iq
);

    assign iq = {map_code(code[5:3]), map_code(code[2:0])};

endmodule

// File: rtl/qam64_frame_sequencer.sv
// rtl/qam64_frame_sequencer.sv - frame header hunt, symbol store fill and SPI/memory port arbitration
// Optional QAM_FRAME_CNT_EN adds a completed-frame counter at register 514.
module qam64_frame_sequencer
    import qam64_pkg::*;
#(
    parameter logic [5:0] HDR0        = HDR0_DEFAULT,
    parameter logic [5:0] HDR1        = HDR1_DEFAULT,
    parameter int         PAYLOAD_LEN = 512
) (
    input  logic       sym_clk,
    input  logic       rst,
    input  logic       sym_valid,
    input  logic [5:0] sym_data,
    input  logic       spi_req,
    input  logic       spi_we,
    input  logic [9:0] spi_addr,
    input  logic [7:0] spi_wdata,
    output logic       spi_ack,
    output logic [7:0] spi_rdata,
    output logic       mem_we,
    output logic [8:0] mem_addr,
    output logic [7:0] mem_wdata,
    input  logic [7:0] mem_rdata,
    output logic       busy,
    output logic       frame_done,
    output logic       frame_abort
);

    localparam logic [8:0] LAST_IDX = 9'(PAYLOAD_LEN - 1);

    state_t     state, state_nxt;
    logic [8:0] idx, idx_nxt;
    logic       sym_wr, done_nxt, abort_nxt;
    logic [7:0] sym_mapped;

    logic       map_en;
    logic [7:0] scratch;
    logic       pend, acc1, acc2, grant;
    logic       req_we;
    logic [9:0] req_addr;
    logic [7:0] req_wdata;
    logic [7:0] rd_val;

`ifdef QAM_FRAME_CNT_EN
    logic [7:0] fcnt;
`endif

    qam64_symbol_mapper u_mapper (
        .code (sym_data),
        .iq   (sym_mapped)
    );

    assign busy = (state == FILL);

    always_ff @(posedge sym_clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            idx   <= 9'd0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        sym_wr    = 1'b0;
        done_nxt  = 1'b0;
        abort_nxt = 1'b0;
        if (!map_en) begin
            state_nxt = IDLE;
            abort_nxt = (state == FILL);
        end else if (sym_valid) begin
            case (state)
                IDLE: if (sym_data == HDR0) state_nxt = HDR;
                HDR: begin
                    if (sym_data == HDR1) begin
                        state_nxt = FILL;
                        idx_nxt   = 9'd0;
                    end else if (sym_data != HDR0) begin
                        state_nxt = IDLE;
                    end
                end
                FILL: begin
                    sym_wr  = 1'b1;
                    idx_nxt = idx + 9'd1;
                    if (idx == LAST_IDX) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // One request in flight at a time: grant only when no symbol owns the port this cycle.
    assign grant = pend && !acc1 && !acc2 && !sym_wr;

    always_comb begin
        rd_val = 8'h00;
        if (!req_addr[9]) begin
            rd_val = mem_rdata;
        end else if (req_addr == ADDR_CTRL) begin
            rd_val[CTRL_MAP_EN_BIT] = map_en;
            rd_val[CTRL_BUSY_BIT]   = busy;
        end else if (req_addr == ADDR_SCRATCH) begin
            rd_val = scratch;
`ifdef QAM_FRAME_CNT_EN
        end else if (req_addr == ADDR_FCNT) begin
            rd_val = fcnt;
`endif
        end
    end

    always_ff @(posedge sym_clk or posedge rst) begin
        if (rst) begin
            spi_ack     <= 1'b0;
            spi_rdata   <= 8'h00;
            mem_we      <= 1'b0;
            mem_addr    <= 9'd0;
            mem_wdata   <= 8'h00;
            frame_done  <= 1'b0;
            frame_abort <= 1'b0;
            map_en      <= 1'b0;
            scratch     <= 8'h00;
            pend        <= 1'b0;
            acc1        <= 1'b0;
            acc2        <= 1'b0;
            req_we      <= 1'b0;
            req_addr    <= 10'd0;
            req_wdata   <= 8'h00;
        end else begin
            mem_we      <= 1'b0;
            spi_ack     <= 1'b0;
            frame_done  <= done_nxt;
            frame_abort <= abort_nxt;
            acc1        <= grant;
            acc2        <= acc1;
            if (spi_req && !pend && !acc1 && !acc2) begin
                pend      <= 1'b1;
                req_we    <= spi_we;
                req_addr  <= spi_addr;
                req_wdata <= spi_wdata;
            end
            if (grant) pend <= 1'b0;
            if (sym_wr) begin
                mem_we    <= 1'b1;
                mem_addr  <= idx;
                mem_wdata <= sym_mapped;
            end else if (grant && !req_addr[9]) begin
                mem_we    <= req_we && !busy;
                mem_addr  <= req_addr[8:0];
                mem_wdata <= req_wdata;
            end
            if (acc2) begin
                spi_ack   <= 1'b1;
                spi_rdata <= rd_val;
                if (req_we && req_addr == ADDR_CTRL) map_en <= req_wdata[CTRL_MAP_EN_BIT];
                if (req_we && req_addr == ADDR_SCRATCH) scratch <= req_wdata;
            end
        end
    end

`ifdef QAM_FRAME_CNT_EN
    always_ff @(posedge sym_clk or posedge rst) begin
        if (rst) fcnt <= 8'd0;
        else if (acc2 && req_we && req_addr == ADDR_FCNT) fcnt <= 8'd0;
        else if (frame_done) fcnt <= fcnt + 8'd1;
    end
`endif

endmodule

// File: tb/tb_qam64_frame_sequencer.sv
// tb/tb_qam64_frame_sequencer.sv - directed self-checking bench for qam64_frame_sequencer
module tb_qam64_frame_sequencer;

    logic       sym_clk = 1'b0;
    logic       rst = 1'b1;
    logic       sym_valid = 1'b0;
    logic [5:0] sym_data = 6'd0;
    logic       spi_req = 1'b0;
    logic       spi_we = 1'b0;
    logic [9:0] spi_addr = 10'd0;
    logic [7:0] spi_wdata = 8'h00;
    logic       spi_ack;
    logic [7:0] spi_rdata;
    logic       mem_we;
    logic [8:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
    logic       busy, frame_done, frame_abort;

    int errors = 0;
    int checks = 0;

    logic [7:0] mem [512];
    int wr_cnt = 0, done_cnt = 0, abort_cnt = 0, ack_cnt = 0, busy_cnt = 0;
    logic [5:0] pay [512];
    logic [5:0] pay2 [37];

    always #5 sym_clk = ~sym_clk;

    qam64_frame_sequencer dut (
        .sym_clk(sym_clk), .rst(rst), .sym_valid(sym_valid), .sym_data(sym_data),
        .spi_req(spi_req), .spi_we(spi_we), .spi_addr(spi_addr), .spi_wdata(spi_wdata),
        .spi_ack(spi_ack), .spi_rdata(spi_rdata), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy),
        .frame_done(frame_done), .frame_abort(frame_abort)
    );

    // External 512x8 single-port memory with one cycle read latency, plus event counters.
    always @(posedge sym_clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
        if (mem_we) wr_cnt <= wr_cnt + 1;
        if (frame_done) done_cnt <= done_cnt + 1;
        if (frame_abort) abort_cnt <= abort_cnt + 1;
        if (spi_ack) ack_cnt <= ack_cnt + 1;
        if (busy) busy_cnt <= busy_cnt + 1;
    end

    function automatic logic [3:0] exp_nib(input logic [2:0] k);
        case (k)
            3'd0: return 4'h7;
            3'd1: return 4'h5;
            3'd2: return 4'h3;
            3'd3: return 4'h1;
            3'd4: return 4'hF;
            3'd5: return 4'hD;
            3'd6: return 4'hB;
            default: return 4'h9;
        endcase
    endfunction

    function automatic logic [7:0] exp_byte(input logic [5:0] s);
        return {exp_nib(s[5:3]), exp_nib(s[2:0])};
    endfunction

    task automatic send_sym(input logic [5:0] d);
        @(negedge sym_clk);
        sym_valid = 1'b1;
        sym_data  = d;
    endtask

    task automatic sym_idle();
        @(negedge sym_clk);
        sym_valid = 1'b0;
    endtask

    task automatic spi_access(input logic we, input logic [9:0] addr, input logic [7:0] wd,
                              output logic [7:0] rd, output int lat);
        int cnt;
        logic got;
        @(negedge sym_clk);
        spi_req = 1'b1; spi_we = we; spi_addr = addr; spi_wdata = wd;
        cnt = 0;
        got = 1'b0;
        while (cnt < 100 && !got) begin
            @(negedge sym_clk);
            spi_req = 1'b0;
            cnt++;
            if (spi_ack === 1'b1) got = 1'b1;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL spi_timeout addr=%0d: ack=%b after %0d cycles, required ack=1", addr, spi_ack, cnt);
        end
        lat = cnt - 1;
        rd  = spi_rdata;
    endtask

    task automatic test_reset();
        logic [7:0] rd;
        int lat;
        repeat (3) @(negedge sym_clk);
        checks++; if ({spi_ack, mem_we, busy, frame_done, frame_abort} !== 5'b0) begin errors++; $display("FAIL reset_flags: got %b required 00000", {spi_ack, mem_we, busy, frame_done, frame_abort}); end
        checks++; if ({spi_rdata, mem_addr, mem_wdata} !== 25'h0) begin errors++; $display("FAIL reset_data: got %h required 0", {spi_rdata, mem_addr, mem_wdata}); end
        rst = 1'b0;
        spi_access(1'b0, 10'd512, 8'h00, rd, lat);
        checks++; if (rd !== 8'h00) begin errors++; $display("FAIL reset_ctrl: got %h required 00", rd); end
        checks++; if (lat !== 3) begin errors++; $display("FAIL reset_latency: got %0d required 3", lat); end
        spi_access(1'b0, 10'd513, 8'h00, rd, lat);
        checks++; if (rd !== 8'h00) begin errors++; $display("FAIL reset_scratch: got %h required 00", rd); end
    endtask

    task automatic test_map_disabled();
        int w0, b0, d0;
        w0 = wr_cnt; b0 = busy_cnt; d0 = done_cnt;
        send_sym(6'b101100);
        send_sym(6'b111000);
        for (int i = 0; i < 512; i++) send_sym(pay[i]);
        sym_idle();
        repeat (3) @(negedge sym_clk);
        checks++; if (wr_cnt - w0 !== 0) begin errors++; $display("FAIL disabled_writes: got %0d required 0", wr_cnt - w0); end
        checks++; if (busy_cnt - b0 !== 0 || busy !== 1'b0) begin errors++; $display("FAIL disabled_busy: got %0d cycles required 0", busy_cnt - b0); end
        checks++; if (done_cnt - d0 !== 0) begin errors++; $display("FAIL disabled_done: got %0d required 0", done_cnt - d0); end
    endtask

    task automatic test_frame();
        logic [7:0] rd;
        int lat, w0, d0, bad, badlat;
        spi_access(1'b1, 10'd512, 8'h01, rd, lat);
        checks++; if (lat !== 3) begin errors++; $display("FAIL ctrl_write_latency: got %0d required 3", lat); end
        w0 = wr_cnt; d0 = done_cnt;
        send_sym(6'b101100);
        send_sym(6'b111000);
        for (int i = 0; i < 512; i++) begin
            send_sym(pay[i]);
            if (i == 0) begin
                checks++; if (busy !== 1'b1) begin errors++; $display("FAIL fill_busy_rise: got %b required 1", busy); end
            end
            if (i == 1) begin
                checks++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 9'd0, 8'h79}) begin errors++; $display("FAIL first_write: got we=%b addr=%0d data=%h required we=1 addr=0 data=79", mem_we, mem_addr, mem_wdata); end
            end
        end
        sym_idle();
        checks++; if ({frame_done, busy, mem_we, mem_addr} !== {1'b1, 1'b0, 1'b1, 9'd511}) begin errors++; $display("FAIL last_write: got done=%b busy=%b we=%b addr=%0d required done=1 busy=0 we=1 addr=511", frame_done, busy, mem_we, mem_addr); end
        repeat (3) @(negedge sym_clk);
        checks++; if (wr_cnt - w0 !== 512) begin errors++; $display("FAIL frame_writes: got %0d required 512", wr_cnt - w0); end
        checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL frame_done_count: got %0d required 1", done_cnt - d0); end
        bad = 0;
        for (int i = 0; i < 512; i++) if (mem[i] !== exp_byte(pay[i])) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL frame_content: got %0d bad entries required 0", bad); end
        bad = 0; badlat = 0;
        for (int i = 0; i < 512; i++) begin
            spi_access(1'b0, 10'(i), 8'h00, rd, lat);
            if (rd !== exp_byte(pay[i])) bad++;
            if (lat != 3) badlat++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL readback_data: got %0d bad reads required 0", bad); end
        checks++; if (badlat != 0) begin errors++; $display("FAIL readback_latency: got %0d slow reads required 0", badlat); end
    endtask

    task automatic test_bad_header();
        int w0;
        w0 = wr_cnt;
        send_sym(6'b101010);
        send_sym(6'b101010);
        send_sym(6'b000000);
        sym_idle();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bad_header_busy: got %b required 0", busy); end
        repeat (2) @(negedge sym_clk);
        checks++; if (wr_cnt - w0 !== 0) begin errors++; $display("FAIL bad_header_writes: got %0d required 0", wr_cnt - w0); end
        send_sym(6'b101100);
        send_sym(6'b101100);
        send_sym(6'b111000);
        sym_idle();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL repeated_hdr0_fill: got busy=%b required 1", busy); end
    endtask

    task automatic test_fill_spi();
        logic [7:0] rd;
        int lat, w0;
        spi_access(1'b0, 10'd512, 8'h00, rd, lat);
        checks++; if (rd !== 8'h03) begin errors++; $display("FAIL ctrl_in_fill: got %h required 03", rd); end
        w0 = wr_cnt;
        spi_access(1'b1, 10'd100, 8'hA5, rd, lat);
        @(negedge sym_clk);
        checks++; if (wr_cnt - w0 !== 0 || mem[100] !== exp_byte(pay[100])) begin errors++; $display("FAIL busy_write_ignored: got mem=%h required %h", mem[100], exp_byte(pay[100])); end
    endtask

    task automatic test_abort();
        logic [7:0] rd;
        int lat, a0, bad;
        a0 = abort_cnt;
        for (int i = 0; i < 37; i++) send_sym(pay2[i]);
        sym_idle();
        spi_access(1'b1, 10'd512, 8'h00, rd, lat);
        @(negedge sym_clk);
        checks++; if ({frame_abort, busy} !== 2'b10) begin errors++; $display("FAIL abort_pulse: got abort=%b busy=%b required abort=1 busy=0", frame_abort, busy); end
        repeat (2) @(negedge sym_clk);
        checks++; if (abort_cnt - a0 !== 1) begin errors++; $display("FAIL abort_count: got %0d required 1", abort_cnt - a0); end
        bad = 0;
        for (int i = 0; i < 37; i++) if (mem[i] !== exp_byte(pay2[i])) bad++;
        for (int i = 37; i < 512; i++) if (mem[i] !== exp_byte(pay[i])) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL abort_content: got %0d bad entries required 0", bad); end
    endtask

    task automatic test_scratch();
        logic [7:0] rd;
        int lat;
        spi_access(1'b1, 10'd513, 8'h5C, rd, lat);
        spi_access(1'b0, 10'd513, 8'h00, rd, lat);
        checks++; if (rd !== 8'h5C) begin errors++; $display("FAIL scratch_readback: got %h required 5c", rd); end
        spi_access(1'b1, 10'd5, 8'h3C, rd, lat);
        spi_access(1'b0, 10'd5, 8'h00, rd, lat);
        checks++; if (rd !== 8'h3C) begin errors++; $display("FAIL idle_mem_write: got %h required 3c", rd); end
        spi_access(1'b1, 10'd600, 8'hFF, rd, lat);
        spi_access(1'b0, 10'd600, 8'h00, rd, lat);
        checks++; if (rd !== 8'h00) begin errors++; $display("FAIL unmapped_read: got %h required 00", rd); end
        spi_access(1'b0, 10'd514, 8'h00, rd, lat);
`ifdef QAM_FRAME_CNT_EN
        checks++; if (rd !== 8'h01) begin errors++; $display("FAIL frame_count: got %h required 01", rd); end
        spi_access(1'b1, 10'd514, 8'h00, rd, lat);
        spi_access(1'b0, 10'd514, 8'h00, rd, lat);
        checks++; if (rd !== 8'h00) begin errors++; $display("FAIL frame_count_clear: got %h required 00", rd); end
`else
        checks++; if (rd !== 8'h00) begin errors++; $display("FAIL addr514_read: got %h required 00", rd); end
`endif
    endtask

    task automatic test_back_to_back();
        logic [7:0] rd;
        int lat, k;
        logic early;
        spi_access(1'b1, 10'd512, 8'h01, rd, lat);
        send_sym(6'b101100);
        send_sym(6'b111000);
        early = 1'b0;
        for (int j = 0; j < 20; j++) begin
            @(negedge sym_clk);
            if (spi_ack === 1'b1) early = 1'b1;
            sym_valid = 1'b1;
            sym_data  = 6'(j * 5);
            if (j == 2) begin
                spi_req = 1'b1; spi_we = 1'b0; spi_addr = 10'd513;
            end else begin
                spi_req = 1'b0;
            end
        end
        sym_idle();
        if (spi_ack === 1'b1) early = 1'b1;
        k = 0;
        while (k < 50 && spi_ack !== 1'b1) begin
            @(negedge sym_clk);
            k++;
        end
        checks++; if (early) begin errors++; $display("FAIL collision_early_ack: got ack during symbol burst required none"); end
        checks++; if (k !== 3) begin errors++; $display("FAIL collision_latency: got %0d cycles after gap required 3", k); end
        checks++; if (spi_rdata !== 8'h5C) begin errors++; $display("FAIL collision_rdata: got %h required 5c", spi_rdata); end
    endtask

    task automatic test_rst_mid_fill();
        logic [7:0] rd;
        int lat, a0;
        send_sym(6'h15);
        send_sym(6'h2A);
        spi_req = 1'b1; spi_we = 1'b0; spi_addr = 10'd512;
        send_sym(6'h33);
        spi_req = 1'b0;
        a0 = ack_cnt;
        checks++; if ({busy, mem_we} !== 2'b11) begin errors++; $display("FAIL pre_rst_fill: got busy=%b we=%b required 1 1", busy, mem_we); end
        rst = 1'b1;
        #1;
        checks++; if ({spi_ack, mem_we, busy, frame_done, frame_abort} !== 5'b0) begin errors++; $display("FAIL rst_flags: got %b required 00000", {spi_ack, mem_we, busy, frame_done, frame_abort}); end
        checks++; if ({spi_rdata, mem_addr, mem_wdata} !== 25'h0) begin errors++; $display("FAIL rst_data: got %h required 0", {spi_rdata, mem_addr, mem_wdata}); end
        @(negedge sym_clk);
        sym_valid = 1'b0;
        rst = 1'b0;
        repeat (8) @(negedge sym_clk);
        checks++; if (ack_cnt - a0 !== 0) begin errors++; $display("FAIL rst_pending_lost: got %0d acks required 0", ack_cnt - a0); end
        spi_access(1'b0, 10'd512, 8'h00, rd, lat);
        checks++; if (rd !== 8'h00) begin errors++; $display("FAIL rst_ctrl: got %h required 00", rd); end
        spi_access(1'b0, 10'd513, 8'h00, rd, lat);
        checks++; if (rd !== 8'h00) begin errors++; $display("FAIL rst_scratch: got %h required 00", rd); end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        pay[0] = 6'b000111;
        for (int i = 1; i < 512; i++) pay[i] = 6'($urandom_range(0, 63));
        for (int i = 0; i < 37; i++) pay2[i] = pay[i] ^ 6'h2A;
        test_reset();
        test_map_disabled();
        test_frame();
        test_bad_header();
        test_fill_spi();
        test_abort();
        test_scratch();
        test_back_to_back();
        test_rst_mid_fill();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
